// File: rtl/delta_madd_engine.sv
// Delta-encoded histogram / multiply-add engine: signed delta cells d[k], bin value v[k] = sum_{j>=k} d[j].
// Point/range updates and serial scan queries (MIN, MAX, SUM, WSUM) over valid/ready ports.
module delta_madd_engine #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 4,
  parameter int CELL_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_index,
  input  logic [IDX_W-1:0]  cmd_lo,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_flag,
  output logic              err
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RANGE2, S_SCAN, S_RESULT} state_t;
  typedef enum logic [2:0] {
    OP_CLEAR, OP_ADD, OP_SUB, OP_RANGE, OP_FIND_MIN, OP_FIND_MAX, OP_SUM, OP_WSUM
  } op_t;

  state_t                   r_state;
  op_t                      r_op;
  logic signed [CELL_W-1:0] r_cells [DEPTH];
  logic [IDX_W-1:0]         r_k;
  logic [IDX_W-1:0]         r_lo;
  logic [CELL_W-1:0]        r_range_data;
  logic signed [ACC_W-1:0]  r_v;
  logic signed [ACC_W-1:0]  r_sum;
  logic signed [ACC_W-1:0]  r_wsum;
  logic                     r_ovf;
  logic                     r_hit;
  logic [IDX_W-1:0]         r_hit_idx;
  logic                     r_res_valid;
  logic [ACC_W-1:0]         r_res_data;
  logic                     r_res_flag;
  logic                     r_err;

  op_t                      w_cmd_op;
  logic [CELL_W-1:0]        w_cmd_data;
  logic signed [ACC_W-1:0]  w_cell_ext;
  logic signed [ACC_W-1:0]  w_v_next;
  logic signed [ACC_W-1:0]  w_sum_next;
  logic signed [ACC_W-1:0]  w_wsum_next;
  logic                     w_ovf_step;
  logic                     w_nz;
  logic [ACC_W-1:0]         w_k_ext;
  logic [ACC_W-1:0]         w_hit_ext;

  // Signed overflow: operands agree in sign but the wrapped sum does not.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  assign cmd_ready   = (r_state == S_IDLE);
  assign w_cmd_op    = op_t'(cmd_op);
  assign w_cmd_data  = {{(CELL_W-DATA_W){1'b0}}, cmd_data};
  assign w_cell_ext  = {{(ACC_W-CELL_W){r_cells[r_k][CELL_W-1]}}, r_cells[r_k]};
  assign w_v_next    = r_v + w_cell_ext;
  assign w_sum_next  = r_sum + w_v_next;
  assign w_wsum_next = r_wsum + r_sum;
  assign w_ovf_step  = add_ovf(r_v, w_cell_ext, w_v_next)
                     | add_ovf(r_sum, w_v_next, w_sum_next)
                     | add_ovf(r_wsum, r_sum, w_wsum_next);
  assign w_nz        = (w_v_next != '0);
  assign w_k_ext     = {{(ACC_W-IDX_W){1'b0}}, r_k};
  assign w_hit_ext   = {{(ACC_W-IDX_W){1'b0}}, r_hit_idx};

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_flag  = r_res_flag;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the cell array must clear in a single reset cycle, so it is built from flops, not a RAM macro.
      for (int k = 0; k < DEPTH; k++) r_cells[k] <= '0;
      r_state      <= S_IDLE;
      r_op         <= OP_CLEAR;
      r_k          <= '0;
      r_lo         <= '0;
      r_range_data <= '0;
      r_v          <= '0;
      r_sum        <= '0;
      r_wsum       <= '0;
      r_ovf        <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_idx    <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_flag   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_op <= w_cmd_op;
          case (w_cmd_op)
            OP_ADD: r_cells[cmd_index] <= r_cells[cmd_index] + w_cmd_data;
            OP_SUB: r_cells[cmd_index] <= r_cells[cmd_index] - w_cmd_data;
            OP_RANGE: begin
              if (cmd_lo > cmd_index) begin
                r_err <= 1'b1;
              end else begin
                r_cells[cmd_index] <= r_cells[cmd_index] + w_cmd_data;
                if (cmd_lo != '0) begin
                  r_lo         <= cmd_lo - IDX_W'(1);
                  r_range_data <= w_cmd_data;
                  r_state      <= S_RANGE2;
                end
              end
            end
            OP_CLEAR: begin
              r_k     <= '1;
              r_state <= S_CLEAR;
            end
            default: begin
              r_k     <= '1;
              r_v     <= '0;
              r_sum   <= '0;
              r_wsum  <= '0;
              r_ovf   <= 1'b0;
              r_hit   <= 1'b0;
              r_hit_idx <= '0;
              r_state <= S_SCAN;
            end
          endcase
        end

        S_RANGE2: begin
          r_cells[r_lo] <= r_cells[r_lo] - r_range_data;
          r_state       <= S_IDLE;
        end

        S_CLEAR: begin
          r_cells[r_k] <= '0;
          r_k          <= r_k - IDX_W'(1);
          if (r_k == '0) r_state <= S_IDLE;
        end

        S_SCAN: begin
          r_v    <= w_v_next;
          r_sum  <= w_sum_next;
          r_wsum <= w_wsum_next;
          r_ovf  <= r_ovf | w_ovf_step;
          r_k    <= r_k - IDX_W'(1);
          // Walking downward, the latest hit is always the lowest nonzero bin.
          if (w_nz) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_k;
          end
          if (r_op == OP_FIND_MAX && w_nz) begin
            r_res_data  <= w_k_ext;
            r_res_flag  <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_RESULT;
          end else if (r_k == '0) begin
            r_res_valid <= 1'b1;
            r_state     <= S_RESULT;
            case (r_op)
              OP_SUM: begin
                r_res_data <= w_sum_next;
                r_res_flag <= r_ovf | w_ovf_step;
              end
              OP_WSUM: begin
                r_res_data <= w_wsum_next;
                r_res_flag <= r_ovf | w_ovf_step;
              end
              default: begin
                r_res_data <= w_nz ? w_k_ext : (r_hit ? w_hit_ext : '0);
                r_res_flag <= !(w_nz || r_hit);
              end
            endcase
          end
        end

        S_RESULT: if (res_ready) begin
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
